fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
- Arbitrates the single-port 320x240, 2-bit framebuffer RAM between two requesters: the game logic (read/write) and the VGA scanout reader (read-only).
- Sits between both requesters and the RAM's ram_address, ram_read_data, ram_write_enabled and ram_write_data pins.
- Issues at most one RAM access per clock.
- VGA has priority, and a starvation counter bounds how long the game waits.

Parameters:
ADDR_W, 19, RAM address width
DATA_W, 2, pixel width
FB_WORDS, 76800, framebuffer depth (320*240)
RAM_RD_LAT, 1, cycles from ram_address to valid ram_read_data
GAME_MAX_WAIT, 3, consecutive game denials before the game is forced a grant

Ports:
clock  in  1  system clock, all logic on posedge
reset_n  in  1  synchronous, active-low reset
vga_req  in  1  scanout read request, held with vga_addr until acked
vga_addr  in  ADDR_W  scanout read address
vga_ack  out  1  combinational grant; request consumed at this clock edge
vga_rdata  out  DATA_W  scanout read data
vga_rvalid  out  1  vga_rdata valid, one cycle per granted read
gm_req  in  1  game access request
gm_we  in  1  1 = write, 0 = read
gm_addr  in  ADDR_W  game address
gm_wdata  in  DATA_W  game write data
gm_ack  out  1  combinational grant to the game
gm_rdata  out  DATA_W  game read data
gm_rvalid  out  1  gm_rdata valid
clear_req  in  1  pulse: start a hardware framebuffer clear (optional feature)
clear_busy  out  1  clear in progress
ram_address  out  ADDR_W  registered RAM address
ram_read_data  in  DATA_W  RAM read data
ram_write_enabled  out  1  registered RAM write strobe
ram_write_data  out  DATA_W  registered RAM write data

Behaviour:
- Reset (reset_n=0 at an edge): state RUN, wait_cnt=0, read-return pipeline flushed, clear address=0.
- All registered outputs reset to 0 (ram_address, ram_write_enabled, ram_write_data, vga_rvalid, gm_rvalid, clear_busy).
- No rvalid may appear for any access granted before reset.
- Reset asserted mid-clear aborts the clear.
- FSM states: RUN and CLEAR.
- RUN arbitration, evaluated each cycle N:
  - If only one requester is high, it is granted.
  - If both are high, VGA wins unless wait_cnt==GAME_MAX_WAIT, in which case the game wins.
  - Exactly one of vga_ack/gm_ack is high in cycle N; ack depends combinationally on req and registered state.
  - A requester advances to its next request on the edge where its ack is high, so back-to-back grants every cycle are legal.
- wait_cnt:
  - Increments when gm_req=1 and gm_ack=0, saturating at GAME_MAX_WAIT.
  - Clears on a game grant or when gm_req=0.
- Access timing:
  - Grant in cycle N puts ram_address, ram_write_enabled and ram_write_data out in cycle N+1.
  - ram_write_enabled=1 only for a game write.
  - ram_write_data=0 for reads.
  - With no grant, ram_write_enabled=0 and ram_address holds its previous value.
- Read return:
  - A 2-bit owner tag (valid, is_vga) shifts through a RAM_RD_LAT+1 stage pipe.
  - The owner's rvalid is asserted in cycle N+1+RAM_RD_LAT, with rdata = ram_read_data in that cycle.
  - The non-owner's rvalid is 0; writes produce no rvalid.
  - rdata is don't-care when rvalid=0; the bench checks it only with rvalid.
- Addresses >= FB_WORDS are passed through unchecked; keeping addresses in range is the requester's responsibility.

Optional Feature:
- Macro: FB_CLEAR_EN.
- Defined:
  - clear_req=1 in RUN moves the block to CLEAR at the next edge; clear_busy=1 from that cycle.
  - CLEAR writes 0 to addresses 0..FB_WORDS-1, one per cycle.
  - The final write (address FB_WORDS-1) is driven in the cycle before the return to RUN, and clear_busy drops with that return.
  - During CLEAR, gm_ack=0 and wait_cnt is frozen.
  - During CLEAR, each vga_req is acked immediately without a RAM access. Its vga_rvalid follows the normal latency with vga_rdata forced to 0 (black).
  - clear_req during CLEAR is ignored.
  - Reads granted in RUN before entering CLEAR still return their valid data.
- Undefined: clear_req is ignored, clear_busy is tied to 0, and the CLEAR state does not exist.

Test Plan:
1. Reset released; gm_req=1, gm_we=1, gm_addr=38420, gm_wdata=01 for one cycle -> gm_ack=1 same cycle; next cycle ram_address=38420, ram_write_enabled=1, ram_write_data=01; gm_rvalid never asserts.
2. RAM preloaded with 38700=10; game read of 38700 -> gm_rvalid=1 exactly 2 cycles after gm_ack, gm_rdata=10; vga_rvalid stays 0.
3. vga_req and gm_req (read) both held high for 12 cycles -> grant pattern V,V,V,G repeated 3 times; every rvalid is routed to the correct owner in grant order.
4. vga_req=0 and gm_req toggling every cycle -> game granted every cycle it requests; wait_cnt stays 0.
5. Both requesters active, then reset_n=0 for 1 cycle -> all outputs 0; no rvalid in the 3 cycles after reset for pre-reset grants.
6. FB_CLEAR_EN: clear_req pulse with gm_req=1 -> clear_busy high for 76800 cycles; every ram_address 0..76799 written with 00; gm_ack=0 throughout; vga reads return 00; game granted on the first cycle after clear_busy falls.

Source files
------------

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
//
// Shares the single-port 320x240, 2-bit framebuffer RAM between the game
// logic (read/write) and the VGA scanout reader (read-only). At most one RAM
// access is issued per clock. VGA normally wins. A starvation counter forces
// a game grant after GAME_MAX_WAIT consecutive denials.
//
// Optional feature macro: FB_CLEAR_EN
//   Defined   : clear_req starts a hardware clear that writes 0 to every
//               framebuffer word. During the clear, VGA reads return black.
//   Undefined : clear_req is ignored and clear_busy is tied to 0.
//
// Ports
//   clock, reset_n          system clock, synchronous active-low reset
//   vga_req/addr            scanout read request and address
//   vga_ack                 combinational grant to scanout
//   vga_rdata/rvalid        scanout read return
//   gm_req/we/addr/wdata    game access request
//   gm_ack                  combinational grant to game
//   gm_rdata/rvalid         game read return
//   clear_req, clear_busy   framebuffer clear control/status
//   ram_address             registered RAM address
//   ram_read_data           RAM read data
//   ram_write_enabled       registered RAM write strobe
//   ram_write_data          registered RAM write data
// ---------------------------------------------------------------------------
module fb_arbiter #(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 2,
    parameter int FB_WORDS      = 76800,
    parameter int RAM_RD_LAT    = 1,
    parameter int GAME_MAX_WAIT = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [DATA_W-1:0] gm_wdata,
    output logic              gm_ack,
    output logic [DATA_W-1:0] gm_rdata,
    output logic              gm_rvalid,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic              ram_write_enabled,
    output logic [DATA_W-1:0] ram_write_data
);

    localparam int WAIT_W = (GAME_MAX_WAIT < 1) ? 1 : $clog2(GAME_MAX_WAIT + 1);

    logic [WAIT_W-1:0]   r_waitCnt;
    logic [RAM_RD_LAT:0] r_tagValid;
    logic [RAM_RD_LAT:0] r_tagVga;
    logic                w_clearing;

`ifdef FB_CLEAR_EN
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clrAddr;
    // Marks VGA reads acked during a clear; their data is forced to black.
    logic [RAM_RD_LAT:0] r_tagBlack;

    assign w_clearing = (r_state == ST_CLEAR);
    assign vga_rdata  = r_tagBlack[RAM_RD_LAT] ? '0 : ram_read_data;
`else
    logic w_unused_cfg;

    assign w_clearing   = 1'b0;
    assign clear_busy   = 1'b0;
    assign vga_rdata    = ram_read_data;
    assign w_unused_cfg = clear_req | (FB_WORDS == 0);
`endif

    assign gm_rdata   = ram_read_data;
    assign vga_rvalid = r_tagValid[RAM_RD_LAT] &  r_tagVga[RAM_RD_LAT];
    assign gm_rvalid  = r_tagValid[RAM_RD_LAT] & ~r_tagVga[RAM_RD_LAT];

    // Grants are gated by reset so no requester consumes a request whose
    // access is about to be flushed.
    always_comb begin
        vga_ack = 1'b0;
        gm_ack  = 1'b0;
        if (reset_n) begin
            if (w_clearing) begin
                vga_ack = vga_req;
            end else if (vga_req && gm_req) begin
                if (r_waitCnt == WAIT_W'(GAME_MAX_WAIT)) begin
                    gm_ack = 1'b1;
                end else begin
                    vga_ack = 1'b1;
                end
            end else begin
                vga_ack = vga_req;
                gm_ack  = gm_req;
            end
        end
    end

    // RAM command register, starvation counter, read-return tag pipe and
    // clear sequencer. Tag stage 0 lines up with the RAM command cycle; the
    // last stage lines up with valid ram_read_data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_waitCnt         <= '0;
            r_tagValid        <= '0;
            r_tagVga          <= '0;
            ram_address       <= '0;
            ram_write_enabled <= 1'b0;
            ram_write_data    <= '0;
`ifdef FB_CLEAR_EN
            r_state           <= ST_RUN;
            r_clrAddr         <= '0;
            r_tagBlack        <= '0;
            clear_busy        <= 1'b0;
`endif
        end else begin
            for (int i = RAM_RD_LAT; i > 0; i--) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagVga[i]   <= r_tagVga[i-1];
`ifdef FB_CLEAR_EN
                r_tagBlack[i] <= r_tagBlack[i-1];
`endif
            end
            r_tagValid[0]     <= vga_ack | (gm_ack & ~gm_we);
            r_tagVga[0]       <= vga_ack;
            ram_write_enabled <= 1'b0;
`ifdef FB_CLEAR_EN
            r_tagBlack[0]     <= w_clearing;
            if (w_clearing) begin
                ram_address       <= r_clrAddr;
                ram_write_enabled <= 1'b1;
                ram_write_data    <= '0;
                if (r_clrAddr == ADDR_W'(FB_WORDS - 1)) begin
                    r_state    <= ST_RUN;
                    clear_busy <= 1'b0;
                    r_clrAddr  <= '0;
                end else begin
                    r_clrAddr <= r_clrAddr + 1'b1;
                end
            end else
`endif
            begin
                if (gm_ack) begin
                    ram_address       <= gm_addr;
                    ram_write_enabled <= gm_we;
                    ram_write_data    <= gm_we ? gm_wdata : '0;
                end else if (vga_ack) begin
                    ram_address    <= vga_addr;
                    ram_write_data <= '0;
                end
                if (gm_req && !gm_ack) begin
                    if (r_waitCnt != WAIT_W'(GAME_MAX_WAIT)) begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end else begin
                    r_waitCnt <= '0;
                end
`ifdef FB_CLEAR_EN
                if (clear_req) begin
                    r_state    <= ST_CLEAR;
                    clear_busy <= 1'b1;
                    r_clrAddr  <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_arbiter
//
// Directed testbench for fb_arbiter with a behavioural 1-cycle-latency
// framebuffer RAM. Inputs change 1 ns after the rising edge. Outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 2;
    localparam int FB_WORDS = 76800;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              gm_req;
    logic              gm_we;
    logic [ADDR_W-1:0] gm_addr;
    logic [DATA_W-1:0] gm_wdata;
    logic              gm_ack;
    logic [DATA_W-1:0] gm_rdata;
    logic              gm_rvalid;
    logic              clear_req;
    logic              clear_busy;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_read_data;
    logic              ram_write_enabled;
    logic [DATA_W-1:0] ram_write_data;

    logic [DATA_W-1:0] mem [0:FB_WORDS-1];
    logic              memLoaded = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clock = ~clock;

    fb_arbiter dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .vga_req           (vga_req),
        .vga_addr          (vga_addr),
        .vga_ack           (vga_ack),
        .vga_rdata         (vga_rdata),
        .vga_rvalid        (vga_rvalid),
        .gm_req            (gm_req),
        .gm_we             (gm_we),
        .gm_addr           (gm_addr),
        .gm_wdata          (gm_wdata),
        .gm_ack            (gm_ack),
        .gm_rdata          (gm_rdata),
        .gm_rvalid         (gm_rvalid),
        .clear_req         (clear_req),
        .clear_busy        (clear_busy),
        .ram_address       (ram_address),
        .ram_read_data     (ram_read_data),
        .ram_write_enabled (ram_write_enabled),
        .ram_write_data    (ram_write_data)
    );

    // Initial framebuffer contents used by the directed tests.
    function automatic logic [DATA_W-1:0] preloadVal(int a);
        if (a == 38700)               return 2'b10;
        if (a >= 100 && a <= 108)     return 2'((a - 100) % 4);
        if (a >= 200 && a <= 202)     return 2'(3 - (a - 200));
        if (a >= 8 && a <= 16)        return 2'b11;
        if (a == 300)                 return 2'b11;
        if (a == 0)                   return 2'b01;
        if (a == FB_WORDS - 1)        return 2'b10;
        return 2'b00;
    endfunction

    // Behavioural RAM: read-before-write, one cycle read latency. The
    // contents are loaded on the first clock edge.
    always @(posedge clock) begin
        if (!memLoaded) begin
            for (int a = 0; a < FB_WORDS; a++) begin
                mem[a] <= preloadVal(a);
            end
            memLoaded     <= 1'b1;
            ram_read_data <= '0;
        end else begin
            if (ram_write_enabled && ram_address < FB_WORDS) begin
                mem[ram_address] <= ram_write_data;
            end
            if (ram_address < FB_WORDS) begin
                ram_read_data <= mem[ram_address];
            end else begin
                ram_read_data <= '0;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checkCount++;
        if (ram_address !== '0) $display("[TB] FAIL reset_ram_address: got %0d want 0", ram_address); else passCount++;
        checkCount++;
        if (ram_write_enabled !== 1'b0) $display("[TB] FAIL reset_ram_we: got %b want 0", ram_write_enabled); else passCount++;
        checkCount++;
        if (ram_write_data !== '0) $display("[TB] FAIL reset_ram_wdata: got %b want 00", ram_write_data); else passCount++;
        checkCount++;
        if ({vga_rvalid, gm_rvalid} !== 2'b00) $display("[TB] FAIL reset_rvalid: got %b want 00", {vga_rvalid, gm_rvalid}); else passCount++;
        checkCount++;
        if (clear_busy !== 1'b0) $display("[TB] FAIL reset_clear_busy: got %b want 0", clear_busy); else passCount++;
        nextCycle();
        reset_n = 1'b1;
    endtask

    task automatic test_game_write();
        int rvCount;
        rvCount  = 0;
        gm_req   = 1'b1;
        gm_we    = 1'b1;
        gm_addr  = 19'd38420;
        gm_wdata = 2'b01;
        @(negedge clock);
        checkCount++;
        if ({vga_ack, gm_ack} !== 2'b01) $display("[TB] FAIL write_ack: got %b want 01", {vga_ack, gm_ack}); else passCount++;
        nextCycle();
        gm_req = 1'b0;
        gm_we  = 1'b0;
        @(negedge clock);
        checkCount++;
        if (ram_address !== 19'd38420) $display("[TB] FAIL write_ram_address: got %0d want 38420", ram_address); else passCount++;
        checkCount++;
        if (ram_write_enabled !== 1'b1) $display("[TB] FAIL write_ram_we: got %b want 1", ram_write_enabled); else passCount++;
        checkCount++;
        if (ram_write_data !== 2'b01) $display("[TB] FAIL write_ram_wdata: got %b want 01", ram_write_data); else passCount++;
        for (int k = 0; k < 4; k++) begin
            if (gm_rvalid || vga_rvalid) rvCount++;
            nextCycle();
            @(negedge clock);
        end
        checkCount++;
        if (rvCount != 0) $display("[TB] FAIL write_no_rvalid: got %0d rvalid cycles want 0", rvCount); else passCount++;
        checkCount++;
        if (mem[38420] !== 2'b01) $display("[TB] FAIL write_mem: got %b want 01", mem[38420]); else passCount++;
        nextCycle();
    endtask

    task automatic test_game_read();
        gm_req  = 1'b1;
        gm_we   = 1'b0;
        gm_addr = 19'd38700;
        @(negedge clock);
        checkCount++;
        if (gm_ack !== 1'b1) $display("[TB] FAIL read_ack: got %b want 1", gm_ack); else passCount++;
        nextCycle();
        gm_req = 1'b0;
        @(negedge clock);
        checkCount++;
        if ({ram_address, ram_write_enabled, ram_write_data} !== {19'd38700, 1'b0, 2'b00})
            $display("[TB] FAIL read_ram_cmd: got addr %0d we %b wd %b want 38700 0 00", ram_address, ram_write_enabled, ram_write_data);
        else passCount++;
        checkCount++;
        if (gm_rvalid !== 1'b0) $display("[TB] FAIL read_rvalid_early: got %b want 0", gm_rvalid); else passCount++;
        nextCycle();
        @(negedge clock);
        checkCount++;
        if ({vga_rvalid, gm_rvalid} !== 2'b01) $display("[TB] FAIL read_rvalid: got %b want 01", {vga_rvalid, gm_rvalid}); else passCount++;
        checkCount++;
        if (gm_rdata !== 2'b10) $display("[TB] FAIL read_rdata: got %b want 10", gm_rdata); else passCount++;
        nextCycle();
        @(negedge clock);
        checkCount++;
        if (gm_rvalid !== 1'b0) $display("[TB] FAIL read_rvalid_late: got %b want 0", gm_rvalid); else passCount++;
        nextCycle();
    endtask

    task automatic test_priority();
        logic              expOwner [12];
        logic [DATA_W-1:0] expData  [12];
        int                vIdx;
        int                gIdx;
        logic              expG;
        logic              sawV;
        logic              sawG;
        vIdx = 0;
        gIdx = 0;
        expG = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c < 12) begin
                vga_req     = 1'b1;
                gm_req      = 1'b1;
                gm_we       = 1'b0;
                vga_addr    = ADDR_W'(100 + vIdx);
                gm_addr     = ADDR_W'(200 + gIdx);
                expG        = (c % 4 == 3);
                expOwner[c] = !expG;
                expData[c]  = expG ? 2'(3 - gIdx) : 2'(vIdx % 4);
            end else begin
                vga_req = 1'b0;
                gm_req  = 1'b0;
            end
            @(negedge clock);
            sawV = vga_ack;
            sawG = gm_ack;
            if (c < 12) begin
                checkCount++;
                if ({sawV, sawG} !== {!expG, expG}) $display("[TB] FAIL prio_ack_c%0d: got %b want %b", c, {sawV, sawG}, {!expG, expG}); else passCount++;
            end
            if (c >= 2) begin
                checkCount++;
                if ({vga_rvalid, gm_rvalid} !== {expOwner[c-2], !expOwner[c-2]})
                    $display("[TB] FAIL prio_rvalid_c%0d: got %b want %b", c, {vga_rvalid, gm_rvalid}, {expOwner[c-2], !expOwner[c-2]});
                else passCount++;
                checkCount++;
                if ((expOwner[c-2] ? vga_rdata : gm_rdata) !== expData[c-2])
                    $display("[TB] FAIL prio_rdata_c%0d: got %b want %b", c, (expOwner[c-2] ? vga_rdata : gm_rdata), expData[c-2]);
                else passCount++;
            end else begin
                checkCount++;
                if ({vga_rvalid, gm_rvalid} !== 2'b00) $display("[TB] FAIL prio_rvalid_c%0d: got %b want 00", c, {vga_rvalid, gm_rvalid}); else passCount++;
            end
            nextCycle();
            if (sawV) vIdx++;
            if (sawG) gIdx++;
        end
    endtask

    task automatic test_game_toggle();
        logic expG;
        vga_req = 1'b0;
        gm_we   = 1'b0;
        gm_addr = 19'd200;
        for (int c = 0; c < 8; c++) begin
            expG   = (c % 2 == 0);
            gm_req = expG;
            @(negedge clock);
            checkCount++;
            if ({vga_ack, gm_ack} !== {1'b0, expG}) $display("[TB] FAIL toggle_ack_c%0d: got %b want %b", c, {vga_ack, gm_ack}, {1'b0, expG}); else passCount++;
            nextCycle();
        end
        // A starvation count of zero shows up as three VGA wins first.
        for (int c = 0; c < 4; c++) begin
            vga_req  = 1'b1;
            gm_req   = 1'b1;
            vga_addr = 19'd100;
            expG     = (c == 3);
            @(negedge clock);
            checkCount++;
            if ({vga_ack, gm_ack} !== {!expG, expG}) $display("[TB] FAIL toggle_wait_c%0d: got %b want %b", c, {vga_ack, gm_ack}, {!expG, expG}); else passCount++;
            nextCycle();
        end
        vga_req = 1'b0;
        gm_req  = 1'b0;
        repeat (3) nextCycle();
    endtask

    task automatic test_mid_reset();
        int rvCount;
        rvCount  = 0;
        vga_req  = 1'b1;
        gm_req   = 1'b1;
        gm_we    = 1'b0;
        vga_addr = 19'd101;
        gm_addr  = 19'd201;
        nextCycle();
        nextCycle();
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        vga_req = 1'b0;
        gm_req  = 1'b0;
        @(negedge clock);
        checkCount++;
        if ({ram_address, ram_write_enabled, ram_write_data} !== '0)
            $display("[TB] FAIL midreset_ram: got addr %0d we %b wd %b want 0 0 00", ram_address, ram_write_enabled, ram_write_data);
        else passCount++;
        checkCount++;
        if ({vga_rvalid, gm_rvalid, clear_busy} !== 3'b000) $display("[TB] FAIL midreset_flags: got %b want 000", {vga_rvalid, gm_rvalid, clear_busy}); else passCount++;
        for (int k = 0; k < 3; k++) begin
            if (vga_rvalid || gm_rvalid) rvCount++;
            nextCycle();
            @(negedge clock);
        end
        checkCount++;
        if (rvCount != 0) $display("[TB] FAIL midreset_no_rvalid: got %0d rvalid cycles want 0", rvCount); else passCount++;
        nextCycle();
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear();
        int   k;
        int   busyCycles;
        int   gmAckBusy;
        int   vgaMissed;
        int   vrErr;
        int   badWrites;
        int   writeIdx;
        int   nonZero;
        logic done;
        logic expV;
        k = 0; busyCycles = 0; gmAckBusy = 0; vgaMissed = 0;
        vrErr = 0; badWrites = 0; writeIdx = 0; nonZero = 0; done = 1'b0;
        clear_req = 1'b1;
        gm_req    = 1'b1;
        gm_we     = 1'b0;
        gm_addr   = 19'd38700;
        vga_req   = 1'b0;
        vga_addr  = 19'd300;
        @(negedge clock);
        checkCount++;
        if ({clear_busy, gm_ack} !== 2'b01) $display("[TB] FAIL clear_pulse_cycle: got busy/ack %b want 01", {clear_busy, gm_ack}); else passCount++;
        nextCycle();
        clear_req = 1'b0;
        while (!done && k < 80000) begin
            vga_req = (k >= 10 && k < 13);
            @(negedge clock);
            if (ram_write_enabled) begin
                if (ram_address != ADDR_W'(writeIdx) || ram_write_data !== 2'b00) badWrites++;
                writeIdx++;
            end
            if (clear_busy) begin
                busyCycles++;
                if (gm_ack) gmAckBusy++;
                if (vga_req && !vga_ack) vgaMissed++;
                expV = (k >= 12 && k <= 14);
                if (vga_rvalid !== expV || (expV && vga_rdata !== 2'b00)) vrErr++;
            end else begin
                done = 1'b1;
                checkCount++;
                if (gm_ack !== 1'b1) $display("[TB] FAIL clear_game_after: got %b want 1", gm_ack); else passCount++;
            end
            if (k == 1) begin
                checkCount++;
                if ({gm_rvalid, gm_rdata} !== 3'b110) $display("[TB] FAIL clear_pre_read: got valid/data %b want 110", {gm_rvalid, gm_rdata}); else passCount++;
            end
            nextCycle();
            k++;
        end
        gm_req  = 1'b0;
        vga_req = 1'b0;
        checkCount++;
        if (!done) $display("[TB] FAIL clear_timeout: clear_busy still %b after %0d cycles", clear_busy, k); else passCount++;
        checkCount++;
        if (busyCycles != FB_WORDS) $display("[TB] FAIL clear_busy_len: got %0d want %0d", busyCycles, FB_WORDS); else passCount++;
        checkCount++;
        if (gmAckBusy != 0) $display("[TB] FAIL clear_gm_ack: got %0d acks want 0", gmAckBusy); else passCount++;
        checkCount++;
        if (vgaMissed != 0 || vrErr != 0) $display("[TB] FAIL clear_vga: got missed %0d bad returns %0d want 0 0", vgaMissed, vrErr); else passCount++;
        checkCount++;
        if (badWrites != 0 || writeIdx != FB_WORDS) $display("[TB] FAIL clear_writes: got bad %0d count %0d want 0 %0d", badWrites, writeIdx, FB_WORDS); else passCount++;
        repeat (3) nextCycle();
        for (int a = 0; a < FB_WORDS; a++) begin
            if (mem[a] !== 2'b00) nonZero++;
        end
        checkCount++;
        if (nonZero != 0) $display("[TB] FAIL clear_mem: got %0d nonzero words want 0", nonZero); else passCount++;
    endtask
`else
    task automatic test_clear_disabled();
        int busyCount;
        busyCount = 0;
        clear_req = 1'b1;
        nextCycle();
        clear_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            gm_req  = (k == 1);
            gm_we   = 1'b0;
            gm_addr = 19'd200;
            @(negedge clock);
            if (clear_busy) busyCount++;
            if (k == 1) begin
                checkCount++;
                if (gm_ack !== 1'b1) $display("[TB] FAIL noclear_game_ack: got %b want 1", gm_ack); else passCount++;
            end
            nextCycle();
        end
        gm_req = 1'b0;
        checkCount++;
        if (busyCount != 0) $display("[TB] FAIL noclear_busy: got %0d busy cycles want 0", busyCount); else passCount++;
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        vga_req   = 1'b0;
        vga_addr  = '0;
        gm_req    = 1'b0;
        gm_we     = 1'b0;
        gm_addr   = '0;
        gm_wdata  = '0;
        clear_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        $display("[TB] starting fb_arbiter tests");
        test_reset();
        test_game_write();
        test_game_read();
        test_priority();
        test_game_toggle();
        test_mid_reset();
`ifdef FB_CLEAR_EN
        test_clear();
`else
        test_clear_disabled();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
